full_adder: RTL and testbench

- Clocked full-adder block: adds two WIDTH-bit operands and a carry-in, and produces a WIDTH-bit sum, a carry-out and a signed-overflow flag.
- Built as a ripple chain of 1-bit full-adder cells with a registered output stage and a simple valid qualifier.
- With WIDTH=1 it is the canonical single-bit full adder (a, b, cin -> sum, cout). It serves as the arithmetic leaf used by the adder family and as the SoC's basic add primitive.

---
 rtl/full_adder.sv | 98 +++++++++
 tb/tb_full_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Ripple-carry adder built from 1-bit full-adder cells, with optional registered outputs.
// WIDTH=1 is the canonical single-bit full adder. The carry chain itself is never pipelined.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign cout_c = carry[WIDTH];
  assign ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        // Result registers hold when no new operands are qualified.
        if (in_valid) begin
          sum_q  <= sum_c;
          cout_q <= cout_c;
          ovf_q  <= ovf_c;
        end
      end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Clock and reset have no function in the bypass configuration.
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;

    assign sum       = sum_c;
    assign cout      = cout_c;
    assign ovf       = ovf_c;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: combinational and registered 1-bit adders plus an
// 8-bit registered adder, with expected results queued at drive time and popped at output.

module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1, REG_OUT=0
  logic c_iv, c_a, c_b, c_cin;
  logic c_sum, c_cout, c_ovf, c_ov;
  // WIDTH=1, REG_OUT=1
  logic r1_iv, r1_a, r1_b, r1_cin;
  logic r1_sum, r1_cout, r1_ovf, r1_ov;
  // WIDTH=8, REG_OUT=1
  logic       r8_iv, r8_cin;
  logic [7:0] r8_a, r8_b, r8_sum;
  logic       r8_cout, r8_ovf, r8_ov;

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .a(c_a), .b(c_b), .cin(c_cin),
    .sum(c_sum), .cout(c_cout), .ovf(c_ovf), .out_valid(c_ov)
  );

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(r1_iv), .a(r1_a), .b(r1_b), .cin(r1_cin),
    .sum(r1_sum), .cout(r1_cout), .ovf(r1_ovf), .out_valid(r1_ov)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .in_valid(r8_iv), .a(r8_a), .b(r8_b), .cin(r8_cin),
    .sum(r8_sum), .cout(r8_cout), .ovf(r8_ovf), .out_valid(r8_ov)
  );

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } res_t;

  res_t sb1[$];
  res_t sb8[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: integer addition; overflow when operand signs agree and the result sign differs.
  function automatic res_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin);
    logic [8:0] t;
    res_t       r;
    int         m;
    m    = w - 1;
    t    = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    r.co = t[w];
    r.ov = (a[m] == b[m]) && (t[m] != a[m]);
    r.s  = (w == 1) ? {7'd0, t[0]} : t[7:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic cin);
    r8_iv  = v;
    r8_a   = a;
    r8_b   = b;
    r8_cin = cin;
    if (v) sb8.push_back(model(8, a, b, cin));
  endtask

  task automatic expect8(input string tag, input logic exp_valid);
    res_t e;
    check({tag, "_valid"}, 64'(r8_ov), 64'(exp_valid));
    if (exp_valid) begin
      if (sb8.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        e = sb8.pop_front();
        check({tag, "_sum"},  64'(r8_sum),  64'(e.s));
        check({tag, "_cout"}, 64'(r8_cout), 64'(e.co));
        check({tag, "_ovf"},  64'(r8_ovf),  64'(e.ov));
      end
    end
  endtask

  initial begin
    res_t e;
    logic [2:0] v;
    c_iv = 0; c_a = 0; c_b = 0; c_cin = 0;
    r1_iv = 0; r1_a = 0; r1_b = 0; r1_cin = 0;
    r8_iv = 0; r8_a = 0; r8_b = 0; r8_cin = 0;

    // Reset state while rst_n is low.
    #2;
    check("rst_r8_sum", 64'(r8_sum), 64'd0);
    check("rst_r8_flags", 64'({r8_cout, r8_ovf, r8_ov}), 64'd0);
    check("rst_r1_all", 64'({r1_sum, r1_cout, r1_ovf, r1_ov}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Combinational 1-bit truth table, including out_valid tracking in_valid.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      c_a = v[2]; c_b = v[1]; c_cin = v[0]; c_iv = v[0] ^ v[1];
      #1;
      e = model(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0]);
      check($sformatf("comb_sum_%0d", i),  64'(c_sum),  64'(e.s));
      check($sformatf("comb_cout_%0d", i), 64'(c_cout), 64'(e.co));
      check($sformatf("comb_ovf_%0d", i),  64'(c_ovf),  64'(e.ov));
      check($sformatf("comb_valid_%0d", i), 64'(c_ov), 64'(v[0] ^ v[1]));
    end

    // Registered 1-bit: eight back-to-back vectors, each result one cycle later.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      r1_iv = 1'b1; r1_a = v[2]; r1_b = v[1]; r1_cin = v[0];
      sb1.push_back(model(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0]));
      tick();
      check($sformatf("r1_valid_%0d", i), 64'(r1_ov), 64'd1);
      e = sb1.pop_front();
      check($sformatf("r1_sum_%0d", i),  64'(r1_sum),  64'(e.s));
      check($sformatf("r1_cout_%0d", i), 64'(r1_cout), 64'(e.co));
      check($sformatf("r1_ovf_%0d", i),  64'(r1_ovf),  64'(e.ov));
    end
    r1_iv = 1'b0;
    tick();
    check("r1_idle_valid", 64'(r1_ov), 64'd0);

    // 8-bit carry/overflow corners, back-to-back.
    drive8(1, 8'hFF, 8'h00, 1'b1); tick(); expect8("wrap", 1);
    drive8(1, 8'h7F, 8'h01, 1'b0); tick(); expect8("posovf", 1);
    drive8(1, 8'h80, 8'h80, 1'b0); tick(); expect8("negovf", 1);
    drive8(1, 8'h00, 8'h00, 1'b0); tick(); expect8("zero", 1);
    check("zero_direct", 64'({r8_sum, r8_cout, r8_ovf}), 64'd0);
    for (int i = 0; i < 12; i++) begin
      drive8(1, 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
      expect8($sformatf("rand_%0d", i), 1);
    end

    // Hold: results stay put and out_valid drops when in_valid is low.
    drive8(1, 8'h12, 8'h34, 1'b0); tick(); expect8("cap46", 1);
    check("cap46_direct", 64'(r8_sum), 64'h46);
    drive8(0, 8'hAA, 8'h55, 1'b1); tick(); expect8("hold", 0);
    check("hold_sum", 64'(r8_sum), 64'h46);
    check("hold_cout", 64'(r8_cout), 64'd0);

    // Async reset between edges after another capture of 0x46.
    drive8(1, 8'h12, 8'h34, 1'b0); tick(); expect8("cap46b", 1);
    drive8(0, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum", 64'(r8_sum), 64'd0);
    check("arst_flags", 64'({r8_cout, r8_ovf, r8_ov}), 64'd0);
    sb8.delete();
    #3 rst_n = 1'b1;

    // Recovery: first edge after release captures.
    drive8(1, 8'h01, 8'h01, 1'b1); tick(); expect8("recover", 1);
    check("recover_direct", 64'({r8_ov, r8_sum}), 64'h103);
    drive8(0, 8'h00, 8'h00, 1'b0); tick(); expect8("tail", 0);
    check("sb_drained", 64'(sb8.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
